pipeline_controller: RTL and testbench
======================================

# pipeline_controller

Central stall/flush sequencer for the 5-stage pipeline. It merges the load-use/branch stall request from hazard detection, the ID-stage branch redirect, and a variable-latency data-memory handshake into one set of per-stage write/flush enables. It also drains the pipeline on a halt instruction, applies a data-memory watchdog, and keeps cycle and stall counters. It sits beside the datapath top and drives the PC and all four pipeline-register enables.

## Interface
- MAX_WAIT, 16, consecutive unanswered dmem cycles before ERROR; 0 disables the watchdog
- CNT_W, 32, width of performance counters
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- hazard_stall  input  1  stall request from hazard detection (load-use or branch operand)
- take_branch  input  1  ID-stage branch resolved taken
- halt_in_id  input  1  halt instruction decoded in ID
- dmem_req  input  1  MEM-stage instruction is a load or store
- dmem_ready  input  1  data memory completes current access this cycle
- dmem_valid  output  1  access request to data memory
- pc_write  output  1  PC update enable
- IF_ID_write / IF_ID_flush  output  1 each  IF/ID hold / zero-to-NOP
- ID_EX_write / ID_EX_flush  output  1 each  ID/EX hold / bubble insert
- EX_MEM_write, MEM_WB_write  output  1 each  stage advance enables
- halted  output  1  pipeline drained after halt (sticky)
- error  output  1  dmem watchdog fired (sticky)
- cycle_count, stall_count  output  CNT_W each  performance counters

## Operation
- States: RUN, DRAIN, HALTED, ERROR. All enable and flag outputs are Mealy-combinational from state and inputs.
- freeze = dmem_req & ~dmem_ready, in RUN or DRAIN. dmem_valid = dmem_req in RUN or DRAIN, else 0.
- Default in RUN: all *_write = 1, all flushes = 0.
- Priority within RUN, highest first:
  - freeze: all *_write = 0, all flushes = 0. Hazard, halt and branch are ignored this cycle and re-evaluated next cycle.
  - hazard_stall: pc_write = 0, IF_ID_write = 0, ID_EX_flush = 1.
  - halt_in_id: pc_write = 0, IF_ID_flush = 1. Go to DRAIN with drain_cnt = 3.
  - take_branch: IF_ID_flush = 1. The PC loads the target.
- DRAIN:
  - pc_write = 0 and IF_ID_flush = 1 every cycle. The other stages advance unless frozen.
  - drain_cnt decrements only on non-frozen cycles. On the edge where it reaches 0, go to HALTED.
  - hazard_stall and take_branch are ignored.
- HALTED: all *_write = 0, flushes = 0, halted = 1. Exit only by rst.
- ERROR: all *_write = 0, flushes = 0, error = 1, halted = 0. Exit only by rst.
- Watchdog:
  - wait_cnt increments on each freeze cycle. It clears on any non-freeze cycle.
  - If MAX_WAIT ≠ 0 and a freeze cycle occurs with wait_cnt == MAX_WAIT-1, go to ERROR at that edge, even if dmem_ready arrives on the next cycle.
- Counters:
  - cycle_count increments every cycle in RUN or DRAIN.
  - stall_count increments in RUN or DRAIN when freeze or hazard_stall is set (hazard_stall counts in RUN only).
  - Both counters wrap modulo 2^CNT_W and freeze in HALTED/ERROR.

## Timing
- While rst is high: state = RUN; drain_cnt, wait_cnt and both counters = 0; halted = 0; error = 0.
- While rst is high, all *_write, all flushes and dmem_valid are forced to 0.
- The first cycle after rst deassertion is in RUN with defaults.
- A reset mid-access or mid-drain abandons the operation immediately. No dmem_valid is issued after reset until dmem_req is seen again.
- Zero-wait memory: dmem_req & dmem_ready in the same cycle causes no freeze, and all stages advance.
- N-cycle memory: dmem_ready arrives on the (N+1)-th cycle of dmem_valid. That gives N frozen cycles, then the pipeline advances on the ready cycle.
- dmem_valid stays high continuously from the first request cycle through the ready cycle.
- State and counter updates are on the rising edge of clk. Reset is asynchronous.
- halt_in_id to halted = 1 takes 4 cycles with no freezes, plus one cycle per frozen DRAIN cycle.

## Test plan
- Reset and idle: rst high 3 cycles, then low with no requests -> all enables 0 during reset. Afterwards pc_write = all *_write = 1 and flushes 0; cycle_count = 5 after 5 cycles; stall_count = 0.
- Load-use with slow memory: hazard_stall = 1 on the same cycle a freeze begins, dmem_ready after 2 freeze cycles -> 2 cycles of all writes 0 with ID_EX_flush = 0. Next cycle: pc_write = 0, IF_ID_write = 0, ID_EX_flush = 1. stall_count = 3.
- Branch: take_branch = 1, no hazard, no dmem_req -> IF_ID_flush = 1, pc_write = 1 for exactly that cycle. Same stimulus with hazard_stall = 1 -> IF_ID_flush = 0, IF_ID_write = 0.
- Halt drain with stall: halt_in_id in cycle 0, freeze in cycle 2 for 1 cycle -> pc_write = 0 and IF_ID_flush = 1 in cycles 0–4. halted = 1 from cycle 5. take_branch during DRAIN is ignored.
- Watchdog at MAX_WAIT = 4: dmem_req held, dmem_ready = 0 -> error = 1 and all writes 0 from the 5th cycle. dmem_ready pulsed afterwards -> still ERROR; counters frozen.
- Reset mid-freeze: rst asserted on the 2nd freeze cycle -> dmem_valid = 0 immediately. After release, wait_cnt restarts from 0 and a new 3-cycle wait at MAX_WAIT = 4 does not fire error.

Source files
------------

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard stalls, branch redirects,
// variable-latency data memory and halt drain into per-stage enables, plus watchdog and counters.
module pipeline_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_stall,
    input  logic             take_branch,
    input  logic             halt_in_id,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             dmem_valid,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_write,
    output logic             ID_EX_flush,
    output logic             EX_MEM_write,
    output logic             MEM_WB_write,
    output logic             halted,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] stall_count
);

    // wait_cnt only needs to reach MAX_WAIT-1 before the watchdog fires
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = (MAX_WAIT > 0) ? WAIT_W'(MAX_WAIT - 1) : '0;
    localparam bit WD_ON = (MAX_WAIT > 0);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED, ERROR} state_t;

    state_t            state;
    logic [1:0]        drain_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              active;
    logic              freeze;
    logic              wd_fire;
    logic              stall_inc;

    assign active    = (state == RUN) || (state == DRAIN);
    assign freeze    = active && dmem_req && !dmem_ready;
    assign wd_fire   = WD_ON && freeze && (wait_cnt == WAIT_LAST);
    assign stall_inc = freeze || ((state == RUN) && hazard_stall);

    always_comb begin
        dmem_valid   = 1'b0;
        pc_write     = 1'b0;
        IF_ID_write  = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_write  = 1'b0;
        ID_EX_flush  = 1'b0;
        EX_MEM_write = 1'b0;
        MEM_WB_write = 1'b0;
        halted       = 1'b0;
        error        = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    dmem_valid = dmem_req;
                    if (!freeze) begin
                        pc_write     = 1'b1;
                        IF_ID_write  = 1'b1;
                        ID_EX_write  = 1'b1;
                        EX_MEM_write = 1'b1;
                        MEM_WB_write = 1'b1;
                        if (hazard_stall) begin
                            pc_write    = 1'b0;
                            IF_ID_write = 1'b0;
                            ID_EX_flush = 1'b1;
                        end else if (halt_in_id) begin
                            pc_write    = 1'b0;
                            IF_ID_flush = 1'b1;
                        end else if (take_branch) begin
                            IF_ID_flush = 1'b1;
                        end
                    end
                end
                // Fetch stays blocked and IF/ID keeps being flushed while older stages finish
                DRAIN: begin
                    dmem_valid   = dmem_req;
                    IF_ID_flush  = 1'b1;
                    IF_ID_write  = !freeze;
                    ID_EX_write  = !freeze;
                    EX_MEM_write = !freeze;
                    MEM_WB_write = !freeze;
                end
                HALTED:  halted = 1'b1;
                ERROR:   error  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            drain_cnt   <= '0;
            wait_cnt    <= '0;
            cycle_count <= '0;
            stall_count <= '0;
        end else if (active) begin
            cycle_count <= cycle_count + CNT_W'(1);
            if (stall_inc) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            wait_cnt <= freeze ? wait_cnt + WAIT_W'(1) : '0;
            if (wd_fire) begin
                state <= ERROR;
            end else if (!freeze) begin
                if (state == RUN) begin
                    if (!hazard_stall && halt_in_id) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd3;
                    end
                end else begin
                    drain_cnt <= drain_cnt - 2'd1;
                    if (drain_cnt == 2'd1) begin
                        state <= HALTED;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed vector table, hand-written corner
// sequences and random stimulus, all compared against a behavioural model of the sequencer.
module tb_pipeline_controller;

    // Output vector bit order: dv pc ifw iff idw idf exw mww halted error
    localparam logic [9:0] O_RST     = 10'b0000000000;
    localparam logic [9:0] O_RUN     = 10'b0110101100;
    localparam logic [9:0] O_FRZ     = 10'b1000000000;
    localparam logic [9:0] O_HAZ     = 10'b0000111100;
    localparam logic [9:0] O_HAZ_RDY = 10'b1000111100;
    localparam logic [9:0] O_BR      = 10'b0111101100;
    localparam logic [9:0] O_HALTID  = 10'b0011101100;
    localparam logic [9:0] O_DRAIN   = 10'b0011101100;
    localparam logic [9:0] O_DRN_FRZ = 10'b1001000000;
    localparam logic [9:0] O_DRN_RDY = 10'b1011101100;
    localparam logic [9:0] O_ZW      = 10'b1110101100;
    localparam logic [9:0] O_HALTED  = 10'b0000000010;
    localparam logic [9:0] O_ERR     = 10'b0000000001;

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_HALTED = 2;
    localparam int M_ERROR  = 3;

    typedef struct {
        string      name;
        bit         r, h, b, hl, req, rdy;
        logic [9:0] exp;
        int         cyc;
        int         st;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hazard_stall = 1'b0, take_branch = 1'b0, halt_in_id = 1'b0;
    logic dmem_req = 1'b0, dmem_ready = 1'b0;

    logic dv_a, pc_a, ifw_a, iff_a, idw_a, idf_a, exw_a, mww_a, halted_a, error_a;
    logic dv_b, pc_b, ifw_b, iff_b, idw_b, idf_b, exw_b, mww_b, halted_b, error_b;
    logic [31:0] cyc_a, st_a;
    logic [2:0]  cyc_b, st_b;
    logic [9:0]  out_a, out_b;

    int          m_mode[2], m_drain[2], m_wait[2];
    int unsigned m_cyc[2], m_st[2];
    int          checks = 0;
    int          failures = 0;
    vec_t        vecs[$];

    always #5 clk = ~clk;

    pipeline_controller #(.MAX_WAIT(4), .CNT_W(32)) dut_a (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .take_branch(take_branch),
        .halt_in_id(halt_in_id), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .dmem_valid(dv_a), .pc_write(pc_a), .IF_ID_write(ifw_a), .IF_ID_flush(iff_a),
        .ID_EX_write(idw_a), .ID_EX_flush(idf_a), .EX_MEM_write(exw_a), .MEM_WB_write(mww_a),
        .halted(halted_a), .error(error_a), .cycle_count(cyc_a), .stall_count(st_a)
    );

    // Watchdog disabled and narrow counters, so wrap-around and the MAX_WAIT=0 case get exercised
    pipeline_controller #(.MAX_WAIT(0), .CNT_W(3)) dut_b (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .take_branch(take_branch),
        .halt_in_id(halt_in_id), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .dmem_valid(dv_b), .pc_write(pc_b), .IF_ID_write(ifw_b), .IF_ID_flush(iff_b),
        .ID_EX_write(idw_b), .ID_EX_flush(idf_b), .EX_MEM_write(exw_b), .MEM_WB_write(mww_b),
        .halted(halted_b), .error(error_b), .cycle_count(cyc_b), .stall_count(st_b)
    );

    assign out_a = {dv_a, pc_a, ifw_a, iff_a, idw_a, idf_a, exw_a, mww_a, halted_a, error_a};
    assign out_b = {dv_b, pc_b, ifw_b, iff_b, idw_b, idf_b, exw_b, mww_b, halted_b, error_b};

    function automatic int max_wait_of(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic int unsigned cnt_mask(input int k, input int unsigned v);
        return (k == 0) ? v : (v & 32'd7);
    endfunction

    function automatic vec_t mk(input string n, input bit r, h, b, hl, req, rdy,
                                input logic [9:0] e, input int c, input int s);
        vec_t v;
        v.name = n; v.r = r; v.h = h; v.b = b; v.hl = hl; v.req = req; v.rdy = rdy;
        v.exp = e; v.cyc = c; v.st = s;
        return v;
    endfunction

    // Expected enables straight from the priority rules of each mode
    function automatic logic [9:0] model_out(input int mode, input bit r, h, b, hl, req, rdy);
        logic [9:0] o;
        bit frz;
        o = '0;
        frz = req && !rdy;
        if (r) return o;
        if (mode == M_HALTED) return O_HALTED;
        if (mode == M_ERROR) return O_ERR;
        o[9] = req;
        if (mode == M_RUN) begin
            if (frz) return o;
            o[8] = 1'b1; o[7] = 1'b1; o[5] = 1'b1; o[3] = 1'b1; o[2] = 1'b1;
            if (h) begin
                o[8] = 1'b0; o[7] = 1'b0; o[4] = 1'b1;
            end else if (hl) begin
                o[8] = 1'b0; o[6] = 1'b1;
            end else if (b) begin
                o[6] = 1'b1;
            end
        end else begin
            o[6] = 1'b1;
            o[7] = !frz; o[5] = !frz; o[3] = !frz; o[2] = !frz;
        end
        return o;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = M_RUN; m_drain[k] = 0; m_wait[k] = 0; m_cyc[k] = 0; m_st[k] = 0;
        end
    endtask

    task automatic modelStep();
        bit frz;
        if (rst) begin
            modelReset();
            return;
        end
        frz = dmem_req && !dmem_ready;
        for (int k = 0; k < 2; k++) begin
            if (m_mode[k] == M_RUN || m_mode[k] == M_DRAIN) begin
                m_cyc[k] = m_cyc[k] + 1;
                if (frz || (m_mode[k] == M_RUN && hazard_stall)) m_st[k] = m_st[k] + 1;
                if (frz) begin
                    m_wait[k] = m_wait[k] + 1;
                    if (max_wait_of(k) != 0 && m_wait[k] >= max_wait_of(k)) m_mode[k] = M_ERROR;
                end else begin
                    m_wait[k] = 0;
                    if (m_mode[k] == M_RUN && !hazard_stall && halt_in_id) begin
                        m_mode[k] = M_DRAIN;
                        m_drain[k] = 3;
                    end else if (m_mode[k] == M_DRAIN) begin
                        m_drain[k] = m_drain[k] - 1;
                        if (m_drain[k] == 0) m_mode[k] = M_HALTED;
                    end
                end
            end
        end
    endtask

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, h, b, hl, req, rdy);
        @(negedge clk);
        rst = r; hazard_stall = h; take_branch = b; halt_in_id = hl;
        dmem_req = req; dmem_ready = rdy;
        if (r) modelReset();
        #1;
    endtask

    task automatic checkOutput(input string name, input bit has_exp, input logic [9:0] exp,
                               input int ecyc, input int est);
        logic [9:0] ma, mb;
        ma = model_out(m_mode[0], rst, hazard_stall, take_branch, halt_in_id, dmem_req, dmem_ready);
        mb = model_out(m_mode[1], rst, hazard_stall, take_branch, halt_in_id, dmem_req, dmem_ready);
        if (has_exp) compare({name, " table_out"}, {22'b0, out_a}, {22'b0, exp});
        if (ecyc >= 0) compare({name, " table_cycle_count"}, cyc_a, ecyc);
        if (est >= 0) compare({name, " table_stall_count"}, st_a, est);
        compare({name, " a_out"}, {22'b0, out_a}, {22'b0, ma});
        compare({name, " a_cycle_count"}, cyc_a, cnt_mask(0, m_cyc[0]));
        compare({name, " a_stall_count"}, st_a, cnt_mask(0, m_st[0]));
        compare({name, " b_out"}, {22'b0, out_b}, {22'b0, mb});
        compare({name, " b_cycle_count"}, {29'b0, cyc_b}, cnt_mask(1, m_cyc[1]));
        compare({name, " b_stall_count"}, {29'b0, st_b}, cnt_mask(1, m_st[1]));
    endtask

    task automatic runCycle(input string name, input bit r, h, b, hl, req, rdy,
                            input bit has_exp, input logic [9:0] exp, input int ecyc, input int est);
        applyStimulus(r, h, b, hl, req, rdy);
        checkOutput(name, has_exp, exp, ecyc, est);
        @(posedge clk);
        modelStep();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        modelReset();

        //                name         r  h  b  hl rq rdy expected   cyc st
        vecs.push_back(mk("reset",     1, 0, 0, 0, 0, 0, O_RST,     0, 0));
        vecs.push_back(mk("reset",     1, 0, 0, 0, 0, 0, O_RST,     0, 0));
        vecs.push_back(mk("reset",     1, 0, 0, 0, 0, 0, O_RST,     0, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("idle",  0, 0, 0, 0, 0, 0, O_RUN,     i, 0));
        vecs.push_back(mk("lu_frz1",   0, 1, 0, 0, 1, 0, O_FRZ,     6, 0));
        vecs.push_back(mk("lu_frz2",   0, 1, 0, 0, 1, 0, O_FRZ,     7, 1));
        vecs.push_back(mk("lu_ready",  0, 1, 0, 0, 1, 1, O_HAZ_RDY, 8, 2));
        vecs.push_back(mk("lu_after",  0, 0, 0, 0, 0, 0, O_RUN,     9, 3));
        vecs.push_back(mk("branch",    0, 0, 1, 0, 0, 0, O_BR,     10, 3));
        vecs.push_back(mk("br_after",  0, 0, 0, 0, 0, 0, O_RUN,    11, 3));
        vecs.push_back(mk("br_hazard", 0, 1, 1, 0, 0, 0, O_HAZ,    12, 3));
        vecs.push_back(mk("idle2",     0, 0, 0, 0, 0, 0, O_RUN,    13, 4));
        vecs.push_back(mk("zero_wait", 0, 0, 0, 0, 1, 1, O_ZW,     14, 4));
        vecs.push_back(mk("halt_c0",   0, 0, 0, 1, 0, 0, O_HALTID, 15, 4));
        vecs.push_back(mk("drain_c1",  0, 0, 0, 0, 0, 0, O_DRAIN,  16, 4));
        vecs.push_back(mk("drain_c2",  0, 0, 1, 0, 1, 0, O_DRN_FRZ,17, 4));
        vecs.push_back(mk("drain_c3",  0, 1, 1, 0, 1, 1, O_DRN_RDY,18, 5));
        vecs.push_back(mk("drain_c4",  0, 0, 1, 0, 0, 0, O_DRAIN,  19, 5));
        vecs.push_back(mk("halted_c5", 0, 0, 0, 0, 0, 0, O_HALTED, 20, 5));
        vecs.push_back(mk("halted_hold",0,1, 1, 1, 1, 0, O_HALTED, 20, 5));
        vecs.push_back(mk("halted_hold",0,1, 1, 0, 1, 1, O_HALTED, 20, 5));

        foreach (vecs[i])
            runCycle(vecs[i].name, vecs[i].r, vecs[i].h, vecs[i].b, vecs[i].hl,
                     vecs[i].req, vecs[i].rdy, 1'b1, vecs[i].exp, vecs[i].cyc, vecs[i].st);

        // Watchdog on the MAX_WAIT=4 instance: four unanswered cycles, then ERROR sticks
        runCycle("wd_reset", 1, 0, 0, 0, 0, 0, 1'b1, O_RST, 0, 0);
        runCycle("wd_idle",  0, 0, 0, 0, 0, 0, 1'b1, O_RUN, 0, 0);
        for (int i = 1; i <= 4; i++)
            runCycle("wd_wait", 0, 0, 0, 0, 1, 0, 1'b1, O_FRZ, i, i - 1);
        runCycle("wd_fired",  0, 0, 0, 0, 1, 0, 1'b1, O_ERR, 5, 4);
        runCycle("wd_ready",  0, 0, 0, 0, 1, 1, 1'b1, O_ERR, 5, 4);
        runCycle("wd_sticky", 0, 1, 1, 1, 0, 0, 1'b1, O_ERR, 5, 4);

        // Reset in the middle of a wait must clear the watchdog count
        runCycle("rmf_reset", 1, 0, 0, 0, 0, 0, 1'b1, O_RST, 0, 0);
        runCycle("rmf_idle",  0, 0, 0, 0, 0, 0, 1'b1, O_RUN, 0, 0);
        runCycle("rmf_frz1",  0, 0, 0, 0, 1, 0, 1'b1, O_FRZ, 1, 0);
        runCycle("rmf_rst",   1, 0, 0, 0, 1, 0, 1'b1, O_RST, 0, 0);
        for (int i = 0; i < 3; i++)
            runCycle("rmf_wait", 0, 0, 0, 0, 1, 0, 1'b1, O_FRZ, i, i);
        runCycle("rmf_ready", 0, 0, 0, 0, 1, 1, 1'b1, O_ZW, 3, 3);
        runCycle("rmf_after", 0, 0, 0, 0, 0, 0, 1'b1, O_RUN, 4, 3);

        for (int i = 0; i < 400; i++) begin
            bit r, h, b, hl, req, rdy;
            r   = ($urandom_range(0, 39) == 0);
            h   = ($urandom_range(0, 3) == 0);
            b   = ($urandom_range(0, 3) == 0);
            hl  = ($urandom_range(0, 14) == 0);
            req = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 1) == 0);
            runCycle("random", r, h, b, hl, req, rdy, 1'b0, O_RST, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
